// File: rtl/wb_select_buf.sv
// Writeback-select stage: picks a data source (with load byte/half extraction),
// tags it with its destination index and queues it in a 2-entry buffer.
module wb_select_buf #(
  parameter int DATA_W    = 32,
  parameter int N_SRC     = 9,
  parameter int SEL_W     = 4,
  parameter int LOAD_IDX  = 1,
  parameter int LUI_IDX   = 7,
  parameter int EXC_CONST = 227,
  parameter int RD_W      = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic [2:0]              ext_mode,
  input  logic [1:0]              addr_lo,
  input  logic [N_SRC*DATA_W-1:0] src_bus,
  input  logic [RD_W-1:0]         rd_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [RD_W-1:0]         out_rd,
  output logic                    out_err
);

  localparam logic [SEL_W-1:0] LOAD_SEL = SEL_W'(LOAD_IDX);
  localparam logic [SEL_W-1:0] EXC_SEL  = SEL_W'(N_SRC);
  localparam logic [SEL_W-1:0] LUI_SEL  = SEL_W'(N_SRC + 1);

  logic [DATA_W-1:0] pick_s;
  logic [DATA_W-1:0] load_word_s;
  logic [15:0]       lui_half_s;
  logic [7:0]        byte_s;
  logic [15:0]       half_s;
  logic [DATA_W-1:0] new_data_s;
  logic              new_err_s;

  logic [DATA_W-1:0] mem_data_r [0:1];
  logic [RD_W-1:0]   mem_rd_r   [0:1];
  logic              mem_err_r  [0:1];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              out_valid_r;
  logic              in_ready_r;
  logic [DATA_W-1:0] head_data_r;
  logic [RD_W-1:0]   head_rd_r;
  logic              head_err_r;

  logic              push_s;
  logic              pop_s;
  logic              rd_ptr_nx_s;
  logic [1:0]        count_nx_s;
  logic [DATA_W-1:0] head_data_nx_s;
  logic [RD_W-1:0]   head_rd_nx_s;
  logic              head_err_nx_s;

  assign load_word_s = src_bus[LOAD_IDX*DATA_W +: DATA_W];
  assign lui_half_s  = src_bus[LUI_IDX*DATA_W +: 16];
  assign half_s      = addr_lo[1] ? load_word_s[31:16] : load_word_s[15:0];

  // AND-OR source mux: an unselected source is masked to zero, so its contents never leak
  always_comb begin
    pick_s = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pick_s = pick_s | (src_bus[i*DATA_W +: DATA_W] & {DATA_W{sel == SEL_W'(i)}});
    end
  end

  // Little-endian byte lane extraction from the load word
  always_comb begin
    case (addr_lo)
      2'd0:    byte_s = load_word_s[7:0];
      2'd1:    byte_s = load_word_s[15:8];
      2'd2:    byte_s = load_word_s[23:16];
      2'd3:    byte_s = load_word_s[31:24];
      default: byte_s = 8'h00;
    endcase
  end

  // Select decode plus load extension; misaligned loads still carry extracted data
  always_comb begin
    new_data_s = '0;
    new_err_s  = 1'b0;
    if (sel == LOAD_SEL) begin
      case (ext_mode)
        3'd0: begin
          new_data_s = load_word_s;
          new_err_s  = (addr_lo != 2'b00);
        end
        3'd1: new_data_s = {{(DATA_W-8){byte_s[7]}}, byte_s};
        3'd2: new_data_s = {{(DATA_W-8){1'b0}}, byte_s};
        3'd3: begin
          new_data_s = {{(DATA_W-16){half_s[15]}}, half_s};
          new_err_s  = addr_lo[0];
        end
        3'd4: begin
          new_data_s = {{(DATA_W-16){1'b0}}, half_s};
          new_err_s  = addr_lo[0];
        end
        default: begin
          new_data_s = '0;
          new_err_s  = 1'b1;
        end
      endcase
    end else if (sel < EXC_SEL) begin
      new_data_s = pick_s;
    end else if (sel == EXC_SEL) begin
      new_data_s = DATA_W'(EXC_CONST);
    end else if (sel == LUI_SEL) begin
      new_data_s = {lui_half_s, {(DATA_W-16){1'b0}}};
    end else begin
      new_err_s = 1'b1;
    end
  end

  assign push_s = in_valid && in_ready_r;
  assign pop_s  = out_valid_r && out_ready;

  // Next occupancy and next head; a fresh push becomes head when the write slot is the next read slot
  always_comb begin
    rd_ptr_nx_s    = rd_ptr_r ^ pop_s;
    head_data_nx_s = '0;
    head_rd_nx_s   = '0;
    head_err_nx_s  = 1'b0;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + 2'd1;
      2'b01:   count_nx_s = count_r - 2'd1;
      default: count_nx_s = count_r;
    endcase
    if (count_nx_s == 2'd0) begin
      head_data_nx_s = '0;
      head_rd_nx_s   = '0;
      head_err_nx_s  = 1'b0;
    end else if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
      head_data_nx_s = new_data_s;
      head_rd_nx_s   = rd_in;
      head_err_nx_s  = new_err_s;
    end else begin
      head_data_nx_s = mem_data_r[rd_ptr_nx_s];
      head_rd_nx_s   = mem_rd_r[rd_ptr_nx_s];
      head_err_nx_s  = mem_err_r[rd_ptr_nx_s];
    end
  end

  // Buffer state and registered handshake/head outputs; flush outranks push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_data_r[i] <= '0;
        mem_rd_r[i]   <= '0;
        mem_err_r[i]  <= 1'b0;
      end
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      head_data_r <= '0;
      head_rd_r   <= '0;
      head_err_r  <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= 1'b0;
      rd_ptr_r    <= 1'b0;
      count_r     <= 2'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      head_data_r <= '0;
      head_rd_r   <= '0;
      head_err_r  <= 1'b0;
    end else begin
      if (push_s) begin
        mem_data_r[wr_ptr_r] <= new_data_s;
        mem_rd_r[wr_ptr_r]   <= rd_in;
        mem_err_r[wr_ptr_r]  <= new_err_s;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      rd_ptr_r    <= rd_ptr_nx_s;
      count_r     <= count_nx_s;
      out_valid_r <= (count_nx_s != 2'd0);
      in_ready_r  <= (count_nx_s != 2'd2);
      head_data_r <= head_data_nx_s;
      head_rd_r   <= head_rd_nx_s;
      head_err_r  <= head_err_nx_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = head_data_r;
  assign out_rd    = head_rd_r;
  assign out_err   = head_err_r;

endmodule

// File: tb/tb_wb_select_buf.sv
// Directed bench for wb_select_buf: decode/extension vector table plus
// backpressure, flush and asynchronous-reset sequences.
module tb_wb_select_buf;

  localparam int DATA_W = 32;
  localparam int N_SRC  = 9;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              sel;
  logic [2:0]              ext_mode;
  logic [1:0]              addr_lo;
  logic [N_SRC*DATA_W-1:0] src_bus;
  logic [4:0]              rd_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [31:0]             out_data;
  logic [4:0]              out_rd;
  logic                    out_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]  sel;
    logic [2:0]  mode;
    logic [1:0]  addr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        err;
  } vec_t;

  vec_t vecs [16];

  wb_select_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .ext_mode  (ext_mode),
    .addr_lo   (addr_lo),
    .src_bus   (src_bus),
    .rd_in     (rd_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] s, input logic [2:0] m, input logic [1:0] a, input logic [4:0] r);
    sel      = s;
    ext_mode = m;
    addr_lo  = a;
    rd_in    = r;
    in_valid = 1'b1;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [31:0] d, input logic [4:0] r, input logic e);
    check({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
    check({tag, ".data"}, out_data, d);
    check({tag, ".rd"}, {27'd0, out_rd}, {27'd0, r});
    check({tag, ".err"}, {31'd0, out_err}, {31'd0, e});
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sel = 4'd0; ext_mode = 3'd0; addr_lo = 2'd0; rd_in = 5'd0;
    for (int i = 0; i < N_SRC; i++) src_bus[i*DATA_W +: DATA_W] = 32'h0101_0101 * (i + 1);
    src_bus[1*DATA_W +: DATA_W] = 32'h80F1_7F02;
    src_bus[3*DATA_W +: DATA_W] = 32'hDEAD_BEEF;
    src_bus[7*DATA_W +: DATA_W] = 32'h0000_ABCD;

    //            sel    mode  addr  rd     data           err
    vecs[0]  = '{4'd3,  3'd0, 2'd0, 5'd5,  32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{4'd9,  3'd0, 2'd0, 5'd6,  32'h0000_00E3, 1'b0};
    vecs[2]  = '{4'd10, 3'd0, 2'd0, 5'd7,  32'hABCD_0000, 1'b0};
    vecs[3]  = '{4'd1,  3'd1, 2'd3, 5'd8,  32'hFFFF_FF80, 1'b0};
    vecs[4]  = '{4'd1,  3'd2, 2'd2, 5'd9,  32'h0000_00F1, 1'b0};
    vecs[5]  = '{4'd1,  3'd3, 2'd2, 5'd10, 32'hFFFF_80F1, 1'b0};
    vecs[6]  = '{4'd1,  3'd4, 2'd1, 5'd11, 32'h0000_7F02, 1'b1};
    vecs[7]  = '{4'd12, 3'd0, 2'd0, 5'd12, 32'h0000_0000, 1'b1};
    vecs[8]  = '{4'd1,  3'd6, 2'd0, 5'd13, 32'h0000_0000, 1'b1};
    vecs[9]  = '{4'd1,  3'd0, 2'd0, 5'd14, 32'h80F1_7F02, 1'b0};
    vecs[10] = '{4'd1,  3'd0, 2'd2, 5'd15, 32'h80F1_7F02, 1'b1};
    vecs[11] = '{4'd3,  3'd6, 2'd1, 5'd16, 32'hDEAD_BEEF, 1'b0};
    vecs[12] = '{4'd1,  3'd1, 2'd1, 5'd17, 32'h0000_007F, 1'b0};
    vecs[13] = '{4'd1,  3'd3, 2'd1, 5'd18, 32'h0000_7F02, 1'b1};
    vecs[14] = '{4'd15, 3'd0, 2'd0, 5'd19, 32'h0000_0000, 1'b1};
    vecs[15] = '{4'd8,  3'd0, 2'd0, 5'd31, 32'h0909_0909, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_head("reset", 1'b0, 32'h0, 5'd0, 1'b0);
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);

    // Decode table, streamed back to back with out_ready high
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].mode, vecs[i].addr, vecs[i].rd);
      @(posedge clk); #1;
      check_head($sformatf("vec%0d", i), 1'b1, vecs[i].data, vecs[i].rd, vecs[i].err);
    end
    @(negedge clk) in_valid = 1'b0;
    @(posedge clk); #1;
    check_head("drained", 1'b0, 32'h0, 5'd0, 1'b0);

    // Backpressure: A, B fill, C held off, then drain in order with C entering on B's pop
    @(negedge clk) out_ready = 1'b0; drive(4'd3, 3'd0, 2'd0, 5'd1);
    @(posedge clk); #1;
    check_head("bp.a", 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0);
    check("bp.a.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) drive(4'd9, 3'd0, 2'd0, 5'd2);
    @(posedge clk); #1;
    check("bp.full.in_ready", {31'd0, in_ready}, 32'd0);
    check_head("bp.full", 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0);
    @(negedge clk) drive(4'd10, 3'd0, 2'd0, 5'd3);
    @(posedge clk); #1;
    check("bp.hold.in_ready", {31'd0, in_ready}, 32'd0);
    check_head("bp.hold", 1'b1, 32'hDEAD_BEEF, 5'd1, 1'b0);
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check_head("bp.b", 1'b1, 32'h0000_00E3, 5'd2, 1'b0);
    check("bp.b.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_head("bp.c", 1'b1, 32'hABCD_0000, 5'd3, 1'b0);
    @(posedge clk); #1;
    check_head("bp.empty", 1'b0, 32'h0, 5'd0, 1'b0);

    // Flush with a full buffer and a concurrent request
    @(negedge clk) out_ready = 1'b0; drive(4'd3, 3'd0, 2'd0, 5'd4);
    @(negedge clk) drive(4'd8, 3'd0, 2'd0, 5'd6);
    @(negedge clk) flush = 1'b1; drive(4'd9, 3'd0, 2'd0, 5'd7);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_head("flush2", 1'b0, 32'h0, 5'd0, 1'b0);
    check("flush2.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("flush2.after", {31'd0, out_valid}, 32'd0);

    // Flush at count 1 drops the same-cycle push
    @(negedge clk) drive(4'd3, 3'd0, 2'd0, 5'd4);
    @(negedge clk) flush = 1'b1; drive(4'd10, 3'd0, 2'd0, 5'd8);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check_head("flush1", 1'b0, 32'h0, 5'd0, 1'b0);
    @(posedge clk); #1;
    check("flush1.after", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset while full
    @(negedge clk) drive(4'd12, 3'd0, 2'd0, 5'd9);
    @(negedge clk) drive(4'd3, 3'd0, 2'd0, 5'd10);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("arst.pre.in_ready", {31'd0, in_ready}, 32'd0);
    check_head("arst.pre", 1'b1, 32'h0, 5'd9, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_head("arst", 1'b0, 32'h0, 5'd0, 1'b0);
    check("arst.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    check("arst.after", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
